// File: rtl/fpdlink_tx_serializer_if.sv
// Pixel-side handshake bundle for the FPD-Link serializer: an RGB666 pixel with sync/enable,
// the VALID/READY handshake, and the pixel-rate strobe.
interface fpdlink_tx_serializer_if;
  logic [5:0] PIX_R;
  logic [5:0] PIX_G;
  logic [5:0] PIX_B;
  logic       PIX_HS;
  logic       PIX_VS;
  logic       PIX_DE;
  logic       PIX_VALID;
  logic       PIX_READY;
  logic       PIX_STB;

  modport master (
    output PIX_R, PIX_G, PIX_B, PIX_HS, PIX_VS, PIX_DE, PIX_VALID,
    input  PIX_READY, PIX_STB
  );

  modport slave (
    input  PIX_R, PIX_G, PIX_B, PIX_HS, PIX_VS, PIX_DE, PIX_VALID,
    output PIX_READY, PIX_STB
  );
endinterface

// File: rtl/fpdlink_tx_serializer.sv
// 7:1 FPD-Link transmitter serializer: one RGB666 word every 7 fast clocks, sent as three data lanes
// plus a clock lane. A one-entry holding register absorbs pixels offered between word loads.
module fpdlink_tx_serializer #(
  parameter logic [6:0] CLK_PATTERN     = 7'b1100011,
  parameter int         UFL_CNT_W       = 8,
  parameter bit         BLANK_HOLD_SYNC = 1'b1
) (
  input  logic                     CLKI,
  input  logic                     RST,
  fpdlink_tx_serializer_if.slave   pix,
  output logic                     TX_D0,
  output logic                     TX_D1,
  output logic                     TX_D2,
  output logic                     TX_CLK,
  output logic                     UNDERFLOW,
  output logic [UFL_CNT_W-1:0]     UFL_COUNT,
  input  logic                     CLR_UFL
);

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } pixel_t;

  logic [2:0]           slot_reg, slot_next;
  logic                 full_reg, full_next;
  pixel_t               hold_reg, hold_next;
  logic                 last_hs_reg, last_hs_next;
  logic                 last_vs_reg, last_vs_next;
  logic                 last_de_reg, last_de_next;
  logic                 ufl_reg, ufl_next;
  logic [UFL_CNT_W-1:0] cnt_reg, cnt_next;

  logic   load;
  logic   ready;
  logic   accept;
  pixel_t in_pix;
  pixel_t blank_pix;
  pixel_t word;
  logic   insert_blank;
  logic [6:0] lane_word [4];

  assign load  = (slot_reg == 3'd6);
  assign ready = !RST && (!full_reg || load);
  assign accept = pix.PIX_VALID && ready;

  assign pix.PIX_READY = ready;
  assign pix.PIX_STB   = load && !RST;

  always_comb begin
    in_pix    = '0;
    in_pix.r  = pix.PIX_R;
    in_pix.g  = pix.PIX_G;
    in_pix.b  = pix.PIX_B;
    in_pix.hs = pix.PIX_HS;
    in_pix.vs = pix.PIX_VS;
    in_pix.de = pix.PIX_DE;

    // Blank words carry no video; sync optionally repeats the last accepted state.
    blank_pix    = '0;
    blank_pix.hs = BLANK_HOLD_SYNC ? last_hs_reg : 1'b0;
    blank_pix.vs = BLANK_HOLD_SYNC ? last_vs_reg : 1'b0;
  end

  always_comb begin
    slot_next    = load ? 3'd0 : slot_reg + 3'd1;
    full_next    = full_reg;
    hold_next    = hold_reg;
    last_hs_next = accept ? in_pix.hs : last_hs_reg;
    last_vs_next = accept ? in_pix.vs : last_vs_reg;
    last_de_next = accept ? in_pix.de : last_de_reg;
    word         = blank_pix;
    insert_blank = 1'b0;

    if (load) begin
      if (full_reg) begin
        word = hold_reg;
        if (accept) begin
          hold_next = in_pix;
        end else begin
          full_next = 1'b0;
        end
      end else if (accept) begin
        word = in_pix;
      end else begin
        insert_blank = 1'b1;
      end
    end else if (accept) begin
      hold_next = in_pix;
      full_next = 1'b1;
    end
  end

  always_comb begin
    ufl_next = ufl_reg;
    cnt_next = cnt_reg;
    // A clear wins over a same-cycle insertion, so that insertion is not counted.
    if (CLR_UFL) begin
      ufl_next = 1'b0;
      cnt_next = '0;
    end else if (insert_blank) begin
      if (cnt_reg != {UFL_CNT_W{1'b1}}) begin
        cnt_next = cnt_reg + 1'b1;
      end
      if (last_de_reg) begin
        ufl_next = 1'b1;
      end
    end
  end

  // Bit 6 of each lane word is slot 0, the first bit on the wire.
  always_comb begin
    lane_word[0] = {word.g[0], word.r};
    lane_word[1] = {word.b[1:0], word.g[5:1]};
    lane_word[2] = {word.de, word.vs, word.hs, word.b[5:2]};
    lane_word[3] = CLK_PATTERN;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [6:0] sh_reg;
      logic [6:0] sh_next;

      always_comb begin
        sh_next = load ? lane_word[gi] : {sh_reg[5:0], 1'b0};
      end

      always_ff @(posedge CLKI) begin
        if (RST) begin
          sh_reg <= '0;
        end else begin
          sh_reg <= sh_next;
        end
      end
    end
  endgenerate

  assign TX_D0  = g_lane[0].sh_reg[6];
  assign TX_D1  = g_lane[1].sh_reg[6];
  assign TX_D2  = g_lane[2].sh_reg[6];
  assign TX_CLK = g_lane[3].sh_reg[6];

  // Reset parks the slot at 6 so the first free-running cycle is a word load.
  always_ff @(posedge CLKI) begin
    if (RST) begin
      slot_reg    <= 3'd6;
      full_reg    <= 1'b0;
      hold_reg    <= '0;
      last_hs_reg <= 1'b0;
      last_vs_reg <= 1'b0;
      last_de_reg <= 1'b0;
      ufl_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      slot_reg    <= slot_next;
      full_reg    <= full_next;
      hold_reg    <= hold_next;
      last_hs_reg <= last_hs_next;
      last_vs_reg <= last_vs_next;
      last_de_reg <= last_de_next;
      ufl_reg     <= ufl_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign UNDERFLOW = ufl_reg;
  assign UFL_COUNT = cnt_reg;

endmodule

// File: tb/tb_fpdlink_tx_serializer.sv
// Bench for fpdlink_tx_serializer: two instances (sync held / sync forced low in blanks) driven
// with the same stimulus, compared against a queue-based word/bit model.
module tb_fpdlink_tx_serializer;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  fpdlink_tx_serializer_if pif1 ();
  fpdlink_tx_serializer_if pif0 ();

  assign pif0.PIX_R     = pif1.PIX_R;
  assign pif0.PIX_G     = pif1.PIX_G;
  assign pif0.PIX_B     = pif1.PIX_B;
  assign pif0.PIX_HS    = pif1.PIX_HS;
  assign pif0.PIX_VS    = pif1.PIX_VS;
  assign pif0.PIX_DE    = pif1.PIX_DE;
  assign pif0.PIX_VALID = pif1.PIX_VALID;

  logic       tx1_d0, tx1_d1, tx1_d2, tx1_clk, ufl1;
  logic       tx0_d0, tx0_d1, tx0_d2, tx0_clk, ufl0;
  logic [7:0] cnt1, cnt0;

  fpdlink_tx_serializer #(.CLK_PATTERN(7'b1100011), .UFL_CNT_W(8), .BLANK_HOLD_SYNC(1'b1)) dut1 (
    .CLKI(clk), .RST(rst), .pix(pif1),
    .TX_D0(tx1_d0), .TX_D1(tx1_d1), .TX_D2(tx1_d2), .TX_CLK(tx1_clk),
    .UNDERFLOW(ufl1), .UFL_COUNT(cnt1), .CLR_UFL(clr)
  );

  fpdlink_tx_serializer #(.CLK_PATTERN(7'b1100011), .UFL_CNT_W(8), .BLANK_HOLD_SYNC(1'b0)) dut0 (
    .CLKI(clk), .RST(rst), .pix(pif0),
    .TX_D0(tx0_d0), .TX_D1(tx0_d1), .TX_D2(tx0_d2), .TX_CLK(tx0_clk),
    .UNDERFLOW(ufl0), .UFL_COUNT(cnt0), .CLR_UFL(clr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         n = 0;
  pix_t       pq[$];
  logic [3:0] q1[$];
  logic [3:0] q0[$];
  logic [3:0] m_tx1 = '0, m_tx0 = '0;
  int         m_cnt = 0;
  logic       m_ufl = 1'b0;
  logic       last_hs = 1'b0, last_vs = 1'b0, last_de = 1'b0;

  // Per-cycle observations and expectations, {CLK, D2, D1, D0}
  logic [3:0] o_tx1, o_tx0, e_tx1, e_tx0;
  logic       o_ready, o_ready0, o_stb, o_ufl, e_ready, e_stb, e_ufl, acc;
  logic [7:0] o_cnt, e_cnt;

  function automatic logic [3:0] lanes(pix_t p, int s);
    logic [6:0] pat;
    logic d0, d1, d2;
    pat = 7'b1100011;
    d0 = (s == 0) ? p.g[0] : p.r[6-s];
    d1 = (s == 0) ? p.b[1] : (s == 1) ? p.b[0] : p.g[7-s];
    d2 = (s == 0) ? p.de : (s == 1) ? p.vs : (s == 2) ? p.hs : p.b[8-s];
    return {pat[6-s], d2, d1, d0};
  endfunction

  function automatic pix_t rand_pix();
    pix_t p;
    p.r  = 6'($urandom);
    p.g  = 6'($urandom);
    p.b  = 6'($urandom);
    p.hs = 1'($urandom);
    p.vs = 1'($urandom);
    p.de = 1'($urandom);
    return p;
  endfunction

  task automatic set_pix(pix_t p, logic v);
    pif1.PIX_R     = p.r;
    pif1.PIX_G     = p.g;
    pif1.PIX_B     = p.b;
    pif1.PIX_HS    = p.hs;
    pif1.PIX_VS    = p.vs;
    pif1.PIX_DE    = p.de;
    pif1.PIX_VALID = v;
  endtask

  // One clock: sample DUT at the falling edge, advance the model, then let the rising edge pass.
  task automatic tick();
    pix_t cur, w, w0;
    logic load;
    @(negedge clk);
    o_tx1    = {tx1_clk, tx1_d2, tx1_d1, tx1_d0};
    o_tx0    = {tx0_clk, tx0_d2, tx0_d1, tx0_d0};
    o_ready  = pif1.PIX_READY;
    o_ready0 = pif0.PIX_READY;
    o_stb    = pif1.PIX_STB;
    o_ufl    = ufl1;
    o_cnt    = cnt1;
    e_tx1    = m_tx1;
    e_tx0    = m_tx0;
    e_ufl    = m_ufl;
    e_cnt    = 8'(m_cnt);
    if (rst) begin
      e_ready = 1'b0; e_stb = 1'b0; acc = 1'b0;
      pq.delete(); q1.delete(); q0.delete();
      m_tx1 = '0; m_tx0 = '0; m_cnt = 0; m_ufl = 1'b0;
      last_hs = 1'b0; last_vs = 1'b0; last_de = 1'b0;
      n = 0;
    end else begin
      load    = (n % 7 == 0);
      e_ready = (pq.size() == 0) || load;
      e_stb   = load;
      acc     = pif1.PIX_VALID && e_ready;
      if (acc) begin
        cur = {pif1.PIX_R, pif1.PIX_G, pif1.PIX_B, pif1.PIX_HS, pif1.PIX_VS, pif1.PIX_DE};
        pq.push_back(cur);
        last_hs = cur.hs; last_vs = cur.vs; last_de = cur.de;
      end
      if (load) begin
        if (pq.size() > 0) begin
          w  = pq.pop_front();
          w0 = w;
        end else begin
          w  = '0; w.hs = last_hs; w.vs = last_vs;
          w0 = '0;
          if (m_cnt < 255) m_cnt++;
          if (last_de) m_ufl = 1'b1;
        end
        for (int s = 0; s < 7; s++) begin
          q1.push_back(lanes(w, s));
          q0.push_back(lanes(w0, s));
        end
      end
      if (clr) begin
        m_cnt = 0;
        m_ufl = 1'b0;
      end
      m_tx1 = q1.pop_front();
      m_tx0 = q0.pop_front();
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1;
    clr = 1'b0;
    set_pix('0, 1'b0);
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pix_t p;
    do_reset(2);
    rst = 1'b1;
    total++; if (o_tx1 !== 4'b0000) begin bad++; $display("FAIL reset_tx got=%b exp=0000", o_tx1); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    total++; if (o_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b exp=0", o_stb); end
    total++; if (o_cnt !== 8'd0 || o_ufl !== 1'b0) begin bad++; $display("FAIL reset_ufl got cnt=%0d ufl=%b exp 0/0", o_cnt, o_ufl); end
    rst = 1'b0;
    p = rand_pix();
    set_pix(p, 1'b1);
    tick();
    total++; if (o_stb !== 1'b1 || o_ready !== 1'b1) begin bad++; $display("FAIL release_stb_ready got stb=%b rdy=%b exp 1/1", o_stb, o_ready); end
    set_pix('0, 1'b0);
    tick();
    total++; if (o_tx1 !== lanes(p, 0)) begin bad++; $display("FAIL bypass_first_bit got=%b exp=%b", o_tx1, lanes(p, 0)); end
    $display("test_reset done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_stream();
    pix_t p;
    logic [6:0] c0, c1, c2, cc;
    logic [3:0] ce;
    c0 = 7'b1101010; c1 = 7'b1101010; c2 = 7'b1011111; cc = 7'b1100011;
    do_reset(2);
    for (int k = 0; k < 70; k++) begin
      if (k == 0) begin
        p = '{r: 6'h2A, g: 6'h15, b: 6'h3F, hs: 1'b1, vs: 1'b0, de: 1'b1};
        set_pix(p, 1'b1);
      end else if (k % 7 == 0) begin
        set_pix(rand_pix(), 1'b1);
      end else begin
        set_pix(rand_pix(), 1'b0);
      end
      tick();
      total++; if (o_tx1 !== e_tx1) begin bad++; $display("FAIL stream_tx k=%0d got=%b exp=%b", k, o_tx1, e_tx1); end
      total++; if (o_ready !== e_ready || o_stb !== e_stb) begin bad++; $display("FAIL stream_hs k=%0d got rdy=%b stb=%b exp %b/%b", k, o_ready, o_stb, e_ready, e_stb); end
      if (k >= 1 && k <= 7) begin
        ce = {cc[7-k], c2[7-k], c1[7-k], c0[7-k]};
        total++; if (o_tx1 !== ce) begin bad++; $display("FAIL stream_first_word k=%0d got=%b exp=%b", k, o_tx1, ce); end
      end
    end
    total++; if (o_cnt !== 8'd0) begin bad++; $display("FAIL stream_ufl_count got=%0d exp=0", o_cnt); end
    $display("test_stream done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_back_to_back();
    pix_t p;
    int idx = 0;
    int k = 0;
    do_reset(2);
    while (idx < 100 && k < 1000) begin
      p = '{r: 6'(idx), g: 6'(idx) ^ 6'h15, b: ~6'(idx), hs: 1'(idx), vs: 1'(idx >> 1), de: 1'b1};
      set_pix(p, 1'b1);
      tick();
      if (acc) idx++;
      total++; if (o_tx1 !== e_tx1) begin bad++; $display("FAIL b2b_tx k=%0d got=%b exp=%b", k, o_tx1, e_tx1); end
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, o_ready, e_ready); end
      // Once the holding register has filled, READY is high only on load cycles.
      if (k >= 2) begin
        total++; if (o_ready !== e_stb) begin bad++; $display("FAIL b2b_ready_pattern k=%0d got=%b exp=%b", k, o_ready, e_stb); end
      end
      k++;
    end
    total++; if (idx != 100) begin bad++; $display("FAIL b2b_accept_count got=%0d exp=100", idx); end
    set_pix('0, 1'b0);
    for (int j = 0; j < 21; j++) begin
      tick();
      total++; if (o_tx1 !== e_tx1) begin bad++; $display("FAIL b2b_drain_tx j=%0d got=%b exp=%b", j, o_tx1, e_tx1); end
    end
    total++; if (o_cnt !== e_cnt) begin bad++; $display("FAIL b2b_ufl_count got=%0d exp=%0d", o_cnt, e_cnt); end
    $display("test_back_to_back done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_underflow();
    pix_t p;
    do_reset(2);
    for (int k = 0; k < 31; k++) begin
      p = rand_pix();
      p.de = 1'b1;
      set_pix(p, (k % 7 == 0) && k != 14 && k != 21);
      tick();
      total++; if (o_tx1 !== e_tx1) begin bad++; $display("FAIL ufl_tx k=%0d got=%b exp=%b", k, o_tx1, e_tx1); end
      if (k == 15 || k == 22) begin
        total++; if (o_tx1[2] !== 1'b0) begin bad++; $display("FAIL ufl_blank_de k=%0d got=%b exp=0", k, o_tx1[2]); end
      end
    end
    total++; if (o_cnt !== 8'd2) begin bad++; $display("FAIL ufl_count got=%0d exp=2", o_cnt); end
    total++; if (o_ufl !== 1'b1) begin bad++; $display("FAIL ufl_flag got=%b exp=1", o_ufl); end
    set_pix('0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    total++; if (o_cnt !== 8'd0 || o_ufl !== 1'b0) begin bad++; $display("FAIL ufl_clear got cnt=%0d ufl=%b exp 0/0", o_cnt, o_ufl); end
    $display("test_underflow done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_blank_sync();
    pix_t p;
    logic [6:0] b2;
    b2 = 7'b0110000;
    do_reset(2);
    for (int k = 0; k < 15; k++) begin
      p = rand_pix();
      p.hs = 1'b1; p.vs = 1'b1; p.de = 1'b1;
      set_pix(p, k == 0);
      tick();
      total++; if (o_tx1 !== e_tx1 || o_tx0 !== e_tx0) begin bad++; $display("FAIL sync_tx k=%0d got=%b/%b exp=%b/%b", k, o_tx1, o_tx0, e_tx1, e_tx0); end
      if (k >= 8) begin
        total++; if (o_tx1[2] !== b2[14-k]) begin bad++; $display("FAIL sync_hold_d2 k=%0d got=%b exp=%b", k, o_tx1[2], b2[14-k]); end
        total++; if (o_tx0[2] !== 1'b0) begin bad++; $display("FAIL sync_zero_d2 k=%0d got=%b exp=0", k, o_tx0[2]); end
      end
    end
    $display("test_blank_sync done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_reset_mid();
    pix_t p;
    do_reset(2);
    for (int k = 0; k < 10; k++) begin
      set_pix(rand_pix(), k % 7 == 0);
      tick();
    end
    rst = 1'b1;
    tick();
    tick();
    total++; if (o_tx1 !== 4'b0000 || o_tx0 !== 4'b0000) begin bad++; $display("FAIL mid_reset_tx got=%b/%b exp=0000", o_tx1, o_tx0); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%b exp=0", o_ready); end
    rst = 1'b0;
    p = rand_pix();
    set_pix(p, 1'b1);
    tick();
    total++; if (o_stb !== 1'b1 || o_ready !== 1'b1) begin bad++; $display("FAIL mid_release got stb=%b rdy=%b exp 1/1", o_stb, o_ready); end
    set_pix('0, 1'b0);
    tick();
    total++; if (o_tx1 !== lanes(p, 0)) begin bad++; $display("FAIL mid_bypass_bit got=%b exp=%b", o_tx1, lanes(p, 0)); end
    $display("test_reset_mid done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_saturate();
    do_reset(2);
    repeat (2100) tick();
    total++; if (o_cnt !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d exp=255", o_cnt); end
    total++; if (o_cnt !== e_cnt) begin bad++; $display("FAIL sat_model got=%0d exp=%0d", o_cnt, e_cnt); end
    total++; if (o_ufl !== 1'b0) begin bad++; $display("FAIL sat_ufl_no_de got=%b exp=0", o_ufl); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++; if (e_stb !== 1'b1 || o_stb !== 1'b1) begin bad++; $display("FAIL sat_clr_on_load got stb=%b exp=1", o_stb); end
    tick();
    total++; if (o_cnt !== 8'd0) begin bad++; $display("FAIL sat_clr_priority got=%0d exp=0", o_cnt); end
    repeat (7) tick();
    total++; if (o_cnt !== 8'd1) begin bad++; $display("FAIL sat_recount got=%0d exp=1", o_cnt); end
    $display("test_saturate done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_random();
    do_reset(2);
    for (int k = 0; k < 700; k++) begin
      set_pix(rand_pix(), ($urandom % 3) != 0);
      clr = ($urandom % 50) == 0;
      tick();
      total++; if (o_tx1 !== e_tx1 || o_tx0 !== e_tx0) begin bad++; $display("FAIL rand_tx k=%0d got=%b/%b exp=%b/%b", k, o_tx1, o_tx0, e_tx1, e_tx0); end
      total++; if (o_ready !== e_ready || o_ready0 !== e_ready || o_stb !== e_stb) begin bad++; $display("FAIL rand_hs k=%0d got rdy=%b stb=%b exp %b/%b", k, o_ready, o_stb, e_ready, e_stb); end
      total++; if (o_cnt !== e_cnt || o_ufl !== e_ufl) begin bad++; $display("FAIL rand_ufl k=%0d got cnt=%0d ufl=%b exp %0d/%b", k, o_cnt, o_ufl, e_cnt, e_ufl); end
    end
    clr = 1'b0;
    $display("test_random done: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    set_pix('0, 1'b0);
    test_reset();
    test_stream();
    test_back_to_back();
    test_underflow();
    test_blank_sync();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
